// File: rtl/imem_decode_unit.sv
// rtl/imem_decode_unit.sv - word instruction memory with combinational read and registered RV32I field/immediate decode
// Optional macro IMEM_DECODE_ILLEGAL_EN adds the registered illegal-opcode flag.
module imem_decode_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] adr,
  input  logic        load,
  input  logic [31:0] in,
  output logic [31:0] out,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  fun3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  fun7,
  output logic [31:0] imm
`ifdef IMEM_DECODE_ILLEGAL_EN
  ,
  output logic        illegal
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0]           mem [DEPTH] = '{default: 32'h0};
  logic [ADDR_WIDTH-1:0] idx;
  logic                  unused_adr_bits;

  // Byte offset and bits above the array size are dropped, so addresses wrap.
  assign idx             = adr[ADDR_WIDTH+1:2];
  assign unused_adr_bits = ^{adr[31:ADDR_WIDTH+2], adr[1:0]};
  assign out             = mem[idx];

  always_ff @(posedge clk) begin
    if (load) begin
      mem[idx] <= in;
    end
  end

  logic [31:0] imm_d, imm_q;
  logic [6:0]  opcode_q, fun7_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [2:0]  fun3_q;

  always_comb begin
    imm_d = 32'h0;
    case (out[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
        imm_d = {{20{out[31]}}, out[31:20]};
      7'b0100011:
        imm_d = {{20{out[31]}}, out[31:25], out[11:7]};
      7'b1100011:
        imm_d = {{19{out[31]}}, out[31], out[7], out[30:25], out[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm_d = {out[31:12], 12'h000};
      7'b1101111:
        imm_d = {{11{out[31]}}, out[31], out[19:12], out[20], out[30:21], 1'b0};
      default:
        imm_d = 32'h0;
    endcase
  end

`ifdef IMEM_DECODE_ILLEGAL_EN
  logic illegal_d, illegal_q;

  always_comb begin
    illegal_d = 1'b1;
    case (out[6:0])
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
      7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011, 7'b0000000:
        illegal_d = 1'b0;
      default:
        illegal_d = 1'b1;
    endcase
    if (out[6:0] != 7'b0 && out[1:0] != 2'b11) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`endif

  // Decode captures the pre-write word when load targets the word being read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= 7'h0;
      rd_q     <= 5'h0;
      fun3_q   <= 3'h0;
      rs1_q    <= 5'h0;
      rs2_q    <= 5'h0;
      fun7_q   <= 7'h0;
      imm_q    <= 32'h0;
    end else begin
      opcode_q <= out[6:0];
      rd_q     <= out[11:7];
      fun3_q   <= out[14:12];
      rs1_q    <= out[19:15];
      rs2_q    <= out[24:20];
      fun7_q   <= out[31:25];
      imm_q    <= imm_d;
    end
  end

  assign opcode = opcode_q;
  assign rd     = rd_q;
  assign fun3   = fun3_q;
  assign rs1    = rs1_q;
  assign rs2    = rs2_q;
  assign fun7   = fun7_q;
  assign imm    = imm_q;

endmodule

// File: tb/tb_imem_decode_unit.sv
// tb/tb_imem_decode_unit.sv - self-checking bench for imem_decode_unit against a behavioural fetch/decode model
module tb_imem_decode_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [31:0] adr = 32'h0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic [6:0]  opcode, fun7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  fun3;
  logic [31:0] imm;
`ifdef IMEM_DECODE_ILLEGAL_EN
  logic        illegal;
`endif

  always #5 clk = ~clk;

  imem_decode_unit #(.ADDR_WIDTH(10)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .adr    (adr),
    .load   (load),
    .in     (din),
    .out    (dout),
    .opcode (opcode),
    .rd     (rd),
    .fun3   (fun3),
    .rs1    (rs1),
    .rs2    (rs2),
    .fun7   (fun7),
    .imm    (imm)
`ifdef IMEM_DECODE_ILLEGAL_EN
    ,
    .illegal(illegal)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: memory as a plain array, decode as the word seen at the last edge.
  logic [31:0] m_mem [1024];
  logic [31:0] m_cap;
  bit          chk_en = 1'b0;

  function automatic int m_idx(input logic [31:0] a);
    return int'((a % 32'd4096) / 32'd4);
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] w);
    int s, hi, lo;
    logic [6:0] op;
    s  = int'(w);
    op = w[6:0];
    if (op == 7'h03 || op == 7'h13 || op == 7'h67 || op == 7'h73) begin
      hi = s >>> 20;
      return hi;
    end
    if (op == 7'h23) begin
      hi = s >>> 25;
      lo = int'((w >> 7) & 32'd31);
      return hi * 32 + lo;
    end
    if (op == 7'h63)
      return (((w >> 8) & 32'd15) << 1) | (((w >> 25) & 32'd63) << 5) |
             (((w >> 7) & 32'd1) << 11) | (w[31] ? 32'hFFFFF000 : 32'h0);
    if (op == 7'h37 || op == 7'h17)
      return w & 32'hFFFFF000;
    if (op == 7'h6F)
      return (((w >> 21) & 32'd1023) << 1) | (((w >> 20) & 32'd1) << 11) |
             (((w >> 12) & 32'd255) << 12) | (w[31] ? 32'hFFF00000 : 32'h0);
    return 32'h0;
  endfunction

  function automatic logic m_illegal(input logic [31:0] w);
    logic [6:0] legal [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                               7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};
    logic found = 1'b0;
    foreach (legal[i]) if (legal[i] == w[6:0]) found = 1'b1;
    return !found || (w[6:0] != 7'h0 && w[1:0] != 2'b11);
  endfunction

  initial foreach (m_mem[i]) m_mem[i] = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cap <= 32'h0;
    end else begin
      m_cap <= m_mem[m_idx(adr)];
      if (load) m_mem[m_idx(adr)] <= din;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out", dout, m_mem[m_idx(adr)]);
      chk("opcode", 32'(opcode), 32'(m_cap[6:0]));
      chk("rd", 32'(rd), 32'(m_cap[11:7]));
      chk("fun3", 32'(fun3), 32'(m_cap[14:12]));
      chk("rs1", 32'(rs1), 32'(m_cap[19:15]));
      chk("rs2", 32'(rs2), 32'(m_cap[24:20]));
      chk("fun7", 32'(fun7), 32'(m_cap[31:25]));
      chk("imm", imm, m_imm(m_cap));
`ifdef IMEM_DECODE_ILLEGAL_EN
      chk("illegal", 32'(illegal), 32'(rst_n ? m_illegal(m_cap) : 1'b0));
`endif
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    adr  = a;
    din  = d;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic rd_word(input logic [31:0] a, input logic [31:0] exp);
    adr = a;
    #1;
    chk("out_comb", dout, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_opcode"}, 32'(opcode), 32'h0);
    chk({nm, "_rd"}, 32'(rd), 32'h0);
    chk({nm, "_fun3"}, 32'(fun3), 32'h0);
    chk({nm, "_rs1"}, 32'(rs1), 32'h0);
    chk({nm, "_rs2"}, 32'(rs2), 32'h0);
    chk({nm, "_fun7"}, 32'(fun7), 32'h0);
    chk({nm, "_imm"}, imm, 32'h0);
  endtask

  initial begin
    chk("model_imm_i", m_imm(32'h00500093), 32'h5);
    chk("model_imm_s", m_imm(32'h0020A423), 32'h8);
    chk("model_imm_b", m_imm(32'hFE000EE3), 32'hFFFFFFFC);
    chk("model_imm_u", m_imm(32'h123452B7), 32'h12345000);
    chk("model_imm_j", m_imm(32'hFF9FF0EF), 32'hFFFFFFF8);

    #2 rst_n = 1'b0;
    #1 chk_zero("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
    rst_n  = 1'b1;
    chk_en = 1'b1;

    wr(32'd0, 32'h00500093);
    rd_word(32'd0, 32'h00500093);
    chk("addi_opcode", 32'(opcode), 32'h13);
    chk("addi_rd", 32'(rd), 32'h1);
    chk("addi_fun3", 32'(fun3), 32'h0);
    chk("addi_rs1", 32'(rs1), 32'h0);
    chk("addi_imm", imm, 32'h5);

    wr(32'd12, 32'h0020A423);
    wr(32'd16, 32'hFE000EE3);
    wr(32'd20, 32'h123452B7);
    wr(32'd24, 32'hFF9FF0EF);

    rd_word(32'd12, 32'h0020A423);
    chk("sw_opcode", 32'(opcode), 32'h23);
    chk("sw_rs1", 32'(rs1), 32'h1);
    chk("sw_rs2", 32'(rs2), 32'h2);
    chk("sw_fun3", 32'(fun3), 32'h2);
    chk("sw_imm", imm, 32'h8);
    rd_word(32'd16, 32'hFE000EE3);
    chk("b_opcode", 32'(opcode), 32'h63);
    chk("b_imm", imm, 32'hFFFFFFFC);
    rd_word(32'd20, 32'h123452B7);
    chk("lui_rd", 32'(rd), 32'h5);
    chk("lui_imm", imm, 32'h12345000);
    rd_word(32'd24, 32'hFF9FF0EF);
    chk("jal_rd", 32'(rd), 32'h1);
    chk("jal_imm", imm, 32'hFFFFFFF8);

    wr(32'd4, 32'hDEADBEEF);
    rd_word(32'd5, 32'hDEADBEEF);
    rd_word(32'd6, 32'hDEADBEEF);
    rd_word(32'd7, 32'hDEADBEEF);
    rd_word(32'd4 + 32'd4096, 32'hDEADBEEF);
    rd_word(32'hFFFF_F004, 32'hDEADBEEF);

    adr  = 32'd8;
    din  = 32'h00000013;
    load = 1'b1;
    #1 chk("rdw_old_out", dout, 32'h0);
    @(posedge clk);
    #1;
    load = 1'b0;
    chk("rdw_opcode_old", 32'(opcode), 32'h0);
    chk("rdw_imm_old", imm, 32'h0);
    chk("rdw_new_out", dout, 32'h00000013);
    @(posedge clk);
    #1 chk("rdw_opcode_new", 32'(opcode), 32'h13);

`ifdef IMEM_DECODE_ILLEGAL_EN
    wr(32'd28, 32'h0000007F);
    wr(32'd32, 32'h00000001);
    rd_word(32'd28, 32'h0000007F);
    chk("ill_7f", 32'(illegal), 32'h1);
    rd_word(32'd32, 32'h00000001);
    chk("ill_lowbits", 32'(illegal), 32'h1);
    rd_word(32'd0, 32'h00500093);
    chk("ill_addi", 32'(illegal), 32'h0);
`endif

    rd_word(32'd0, 32'h00500093);
    chk("pre_rst_opcode", 32'(opcode), 32'h13);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    chk("midrst_out", dout, 32'h00500093);
`ifdef IMEM_DECODE_ILLEGAL_EN
    chk("midrst_illegal", 32'(illegal), 32'h0);
`endif
    @(posedge clk);
    #1 chk_zero("midrst_hold");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_opcode", 32'(opcode), 32'h13);
    chk("post_rst_rd", 32'(rd), 32'h1);
    chk("post_rst_imm", imm, 32'h5);
    rd_word(32'd4, 32'hDEADBEEF);

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
